pmem_burst_adapter: RTL and testbench

- Responder on the cache's 256-bit physical-memory interface; sits below the L2 cache.
- Accepts one whole-line read or write at a time.
- Each line transfer becomes a 4-beat, 64-bit burst on the external memory port.
- Returns a single-cycle line_resp when the line transfer is complete.

---
 rtl/pmem_burst_pkg.sv | 26 ++
 rtl/burst_line_buffer.sv | 32 +++
 rtl/pmem_burst_adapter.sv | 122 ++++++++++++
 tb/tb_pmem_burst_adapter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_burst_pkg.sv
// Shared constants and types for the physical-memory burst adapter.
// A cache line is NUM_BEATS beats of BEAT_W bits, beat 0 in the low bits.
package pmem_burst_pkg;

    localparam int S_OFFSET  = 5;
    localparam int BEAT_W    = 64;
    localparam int NUM_BEATS = 4;
    localparam int CNT_W     = 2;
    localparam int LINE_W    = 256;

    localparam logic [31:0] ADDR_MASK =
        ~((32'd1 << S_OFFSET) - 32'd1);

    localparam logic [CNT_W-1:0] LAST_BEAT =
        CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } pmem_burst_state_t;

    typedef logic [NUM_BEATS-1:0][BEAT_W-1:0] line_t;

endpackage

// File: rtl/burst_line_buffer.sv
// Line buffer shared by read assembly and write slicing.
// Whole-line load has priority over a single-beat write.
module burst_line_buffer
    import pmem_burst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  line_t             load_line,
    input  logic              beat_we,
    input  logic [CNT_W-1:0]  beat_sel,
    input  logic [BEAT_W-1:0] beat_wdata,
    output line_t             line,
    output logic [BEAT_W-1:0] beat_rdata
);

    line_t q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_line;
        end else if (beat_we) begin
            q[beat_sel] <= beat_wdata;
        end
    end

    assign line       = q;
    assign beat_rdata = q[beat_sel];

endmodule

// File: rtl/pmem_burst_adapter.sv
// Turns one 256-bit line read/write into a 4-beat 64-bit burst.
// Every output comes straight from a register; no input reaches an output.
module pmem_burst_adapter
    import pmem_burst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_address,
    output logic [LINE_W-1:0] line_rdata,
    input  logic [LINE_W-1:0] line_wdata,
    input  logic              line_read,
    input  logic              line_write,
    output logic              line_resp,
    output logic [31:0]       burst_address,
    input  logic [BEAT_W-1:0] burst_rdata,
    output logic [BEAT_W-1:0] burst_wdata,
    output logic              burst_read,
    output logic              burst_write,
    input  logic              burst_resp
);

    pmem_burst_state_t state, state_n;

    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       addr_n;
    logic              rd_n, wr_n, resp_n;
    logic [LINE_W-1:0] rdata_n;
    logic              buf_load, buf_we;
    line_t             buf_line, asm_line;

    burst_line_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_line  (line_wdata),
        .beat_we    (buf_we),
        .beat_sel   (cnt),
        .beat_wdata (burst_rdata),
        .line       (buf_line),
        .beat_rdata (burst_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            line_resp     <= 1'b0;
            line_rdata    <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            burst_address <= addr_n;
            burst_read    <= rd_n;
            burst_write   <= wr_n;
            line_resp     <= resp_n;
            line_rdata    <= rdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = burst_address;
        rd_n     = burst_read;
        wr_n     = burst_write;
        resp_n   = 1'b0;
        rdata_n  = line_rdata;
        buf_load = 1'b0;
        buf_we   = 1'b0;
        // Final line = buffer with the beat arriving this cycle merged in.
        asm_line      = buf_line;
        asm_line[cnt] = burst_rdata;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (line_write) begin
                    buf_load = 1'b1;
                    addr_n   = line_address & ADDR_MASK;
                    wr_n     = 1'b1;
                    state_n  = WRITE;
                end else if (line_read) begin
                    addr_n  = line_address & ADDR_MASK;
                    rd_n    = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                if (burst_resp) begin
                    buf_we = 1'b1;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        rd_n    = 1'b0;
                        rdata_n = asm_line;
                        resp_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        wr_n    = 1'b0;
                        resp_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Randomized bench for pmem_burst_adapter with a line-level reference model.
// A bench-side responder feeds beats and checks timing of each line transfer.
module tb_pmem_burst_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  line_address = '0;
    logic [255:0] line_rdata;
    logic [255:0] line_wdata = '0;
    logic         line_read = 1'b0;
    logic         line_write = 1'b0;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic [63:0]  burst_rdata = '0;
    logic [63:0]  burst_wdata;
    logic         burst_read;
    logic         burst_write;
    logic         burst_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    // Model state: what line_rdata must hold (last completed read).
    logic [255:0] last_rdata = '0;

    always #5 clk = ~clk;

    pmem_burst_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .line_address  (line_address),
        .line_rdata    (line_rdata),
        .line_wdata    (line_wdata),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_rdata   (burst_rdata),
        .burst_wdata   (burst_wdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_resp    (burst_resp)
    );

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand64(), rand64(), rand64(), rand64()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line transfer. resp pattern bit i drives burst_resp in burst
    // cycle i (1 after pat_len). Expected line_resp lands exactly on the
    // cycle after the fourth accepted beat, so gaps shift it one-for-one.
    task automatic run_txn(
        input string       name,
        input bit          is_write,
        input bit          both,
        input logic [31:0] addr,
        input logic [255:0] wline,
        input logic [63:0] beats [4],
        input logic [15:0] pat,
        input int          pat_len,
        input bit          stray
    );
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        logic [63:0]  exp_beat;
        bit           wr;
        bit           resp;
        int           k;
        int           cyc;
        wr       = is_write || both;
        exp_addr = addr & 32'hFFFF_FFE0;
        for (int i = 0; i < 4; i++) exp_line[64*i +: 64] = beats[i];
        line_address = addr;
        line_wdata   = wline;
        line_write   = wr;
        line_read    = !is_write || both;
        burst_resp   = 1'b0;
        tick();
        line_address = $urandom();
        line_wdata   = rand256();
        checks++;
        if (burst_address !== exp_addr) begin
            errors++;
            $display("FAIL %s addr: got %h want %h", name, burst_address, exp_addr);
        end
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            resp        = (cyc < pat_len) ? pat[cyc] : 1'b1;
            burst_resp  = resp;
            burst_rdata = resp ? beats[k] : rand64();
            checks++;
            if (burst_read !== !wr || burst_write !== wr || line_resp !== 1'b0) begin
                errors++;
                $display("FAIL %s req k=%0d: rd=%b wr=%b resp=%b want rd=%b wr=%b resp=0",
                         name, k, burst_read, burst_write, line_resp, !wr, wr);
            end
            if (wr) begin
                exp_beat = wline[64*k +: 64];
                checks++;
                if (burst_wdata !== exp_beat) begin
                    errors++;
                    $display("FAIL %s wdata k=%0d: got %h want %h", name, k, burst_wdata, exp_beat);
                end
            end
            tick();
            cyc++;
            if (resp) k++;
        end
        if (k < 4) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d want 4", name, k);
        end
        burst_resp  = stray;
        burst_rdata = rand64();
        if (!wr) last_rdata = exp_line;
        checks++;
        if (line_resp !== 1'b1 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
            errors++;
            $display("FAIL %s done: resp=%b rd=%b wr=%b want resp=1 rd=0 wr=0",
                     name, line_resp, burst_read, burst_write);
        end
        checks++;
        if (line_rdata !== last_rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, line_rdata, last_rdata);
        end
        tick();
        burst_resp = 1'b0;
        line_read  = 1'b0;
        line_write = 1'b0;
        checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: resp=%b rd=%b wr=%b want all 0",
                     name, line_resp, burst_read, burst_write);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0 ||
            line_rdata !== last_rdata) begin
            errors++;
            $display("FAIL %s idle: resp=%b rd=%b wr=%b rdata=%h want 0 0 0 %h",
                     name, line_resp, burst_read, burst_write, line_rdata, last_rdata);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0 ||
            line_rdata !== '0 || burst_address !== '0 || burst_wdata !== '0) begin
            errors++;
            $display("FAIL %s zero: resp=%b rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
                     name, line_resp, burst_read, burst_write, burst_address,
                     burst_wdata, line_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        line_read = 1'b1;
        burst_resp = 1'b1;
        tick();
        tick();
        check_zero("reset");
        line_read = 1'b0;
        burst_resp = 1'b0;
        rst = 1'b1;
        last_rdata = '0;
        tick();
        check_idle("after_reset");
    endtask

    task automatic test_read();
        logic [63:0] b [4];
        b[0] = 64'h1111111111111111;
        b[1] = 64'h2222222222222222;
        b[2] = 64'h3333333333333333;
        b[3] = 64'h4444444444444444;
        run_txn("read", 1'b0, 1'b0, 32'h0000_1234, rand256(), b, 16'h0, 0, 1'b0);
    endtask

    task automatic test_write();
        logic [63:0]  b [4];
        logic [255:0] w;
        w = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("write", 1'b1, 1'b0, 32'h0000_8F1C, w, b, 16'h0, 0, 1'b0);
    endtask

    task automatic test_read_gaps();
        logic [63:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("read_gaps", 1'b0, 1'b0, 32'hCAFE_0047, rand256(), b,
                16'b1011001, 7, 1'b0);
    endtask

    task automatic test_both_high();
        logic [63:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("both_high", 1'b0, 1'b1, 32'h0000_0300, rand256(), b,
                16'b0110, 4, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] b [4];
        line_address = 32'h0000_0980;
        line_read    = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = rand64();
            tick();
        end
        burst_resp  = 1'b1;
        burst_rdata = rand64();
        rst = 1'b0;
        tick();
        check_zero("reset_mid");
        rst        = 1'b1;
        line_read  = 1'b0;
        burst_resp = 1'b0;
        last_rdata = '0;
        tick();
        check_idle("reset_mid_after");
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("fresh_read", 1'b0, 1'b0, 32'h0000_0040, rand256(), b,
                16'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] b [4];
        for (int i = 0; i < 3; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = rand64();
            tick();
            check_idle("stray_idle");
        end
        burst_resp = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("b2b_write", 1'b1, 1'b0, 32'h0000_0020, rand256(), b,
                16'h0, 0, 1'b1);
        for (int i = 0; i < 4; i++) b[i] = rand64();
        run_txn("b2b_read", 1'b0, 1'b0, 32'h0000_0020, rand256(), b,
                16'h0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] b [4];
        logic [15:0] pat;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) b[i] = rand64();
            pat = 16'($urandom()) | 16'($urandom());
            run_txn("random", 1'($urandom_range(0, 1)), 1'b0, $urandom(),
                    rand256(), b, pat, $urandom_range(0, 16),
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_idle("random_gap");
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read_gaps();
        test_both_high();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
